// File: rtl/tcm_pkg.sv
// Shared widths and the response record for the TCM request port.
package tcm_pkg;

    localparam int TCM_ADDR_W      = 16;
    localparam int TCM_WORD_ADDR_W = 14;
    localparam int TCM_ID_W        = 4;

    typedef struct packed {
        logic [31:0]         rdata;
        logic [TCM_ID_W-1:0] id;
        logic                err;
    } tcm_rsp_t;

endpackage

// File: rtl/tcm_rsp_fifo.sv
// Small circular response FIFO with occupancy count; head is read combinationally.
module tcm_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 41,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = pop_i & ~w_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({push_i, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries data only; validity lives entirely in the count.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign valid_o = ~w_empty;
    assign count_o = r_count;

    a_no_push_when_full: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(push_i && w_full)
    );

endmodule

// File: rtl/tcm_mem_req_port.sv
// Valid/ready front-end for one TCM RAM port: address/error decode, byte-lane
// write gating, one-cycle read latency tracking and a response FIFO.
module tcm_mem_req_port
    import tcm_pkg::*;
#(
    parameter int ID_W      = TCM_ID_W,
    parameter int MEM_WORDS = 32,
    parameter int RSP_DEPTH = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [TCM_ADDR_W-1:0]      req_addr_i,
    input  logic [31:0]                req_wdata_i,
    input  logic [3:0]                 req_wstrb_i,
    input  logic [ID_W-1:0]            req_id_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [31:0]                resp_rdata_o,
    output logic [ID_W-1:0]            resp_id_o,
    output logic                       resp_err_o,
    output logic [TCM_WORD_ADDR_W-1:0] ram_addr_o,
    output logic [31:0]                ram_data_o,
    output logic [3:0]                 ram_wr_o,
    input  logic [31:0]                ram_data_i
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [TCM_WORD_ADDR_W-1:0] MEM_WORDS_W = TCM_WORD_ADDR_W'(MEM_WORDS);
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(RSP_DEPTH);

    logic                w_err;
    logic                w_ready;
    logic                w_accept;
    logic                w_pop;
    logic                w_rsp_valid;
    logic [CNT_W-1:0]    w_count;
    logic [CNT_W:0]      w_occupancy;
    tcm_rsp_t            w_push_rsp;
    tcm_rsp_t            w_head_rsp;

    logic                r_inflight;
    logic                r_inflight_err;
    logic [ID_W-1:0]     r_inflight_id;

    assign w_err = (req_addr_i[1:0] != 2'b00) |
                   (req_addr_i[TCM_ADDR_W-1:2] >= MEM_WORDS_W);

    // Count the in-flight read as an occupied slot so the capture can never overflow.
    assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_ready     = rst_ni & (w_occupancy < DEPTH_W);
    assign w_accept    = req_valid_i & w_ready;

    assign req_ready_o = w_ready;
    assign ram_addr_o  = req_addr_i[TCM_ADDR_W-1:2];
    assign ram_data_o  = req_wdata_i;
    assign ram_wr_o    = (w_accept & ~w_err) ? req_wstrb_i : 4'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_inflight_id  <= req_id_i;
            r_inflight_err <= w_err;
        end
    end

    // RAM read data is valid now, one cycle after the address was presented.
    assign w_push_rsp.rdata = r_inflight_err ? 32'h0 : ram_data_i;
    assign w_push_rsp.id    = TCM_ID_W'(r_inflight_id);
    assign w_push_rsp.err   = r_inflight_err;

    assign w_pop = w_rsp_valid & resp_ready_i;

    tcm_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(tcm_rsp_t))
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (r_inflight),
        .data_i  (w_push_rsp),
        .pop_i   (w_pop),
        .data_o  (w_head_rsp),
        .valid_o (w_rsp_valid),
        .count_o (w_count)
    );

    assign resp_valid_o = w_rsp_valid;
    assign resp_rdata_o = w_rsp_valid ? w_head_rsp.rdata : 32'h0;
    assign resp_id_o    = w_rsp_valid ? ID_W'(w_head_rsp.id) : '0;
    assign resp_err_o   = w_rsp_valid & w_head_rsp.err;

endmodule

// File: tb/tb_tcm_mem_req_port.sv
// Directed bench for tcm_mem_req_port with a behavioural read-first RAM.
module tb_tcm_mem_req_port;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [15:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_wstrb_i;
    logic [3:0]  req_id_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic [3:0]  resp_id_o;
    logic        resp_err_o;
    logic [13:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [3:0]  ram_wr_o;
    logic [31:0] ram_data_i;

    logic [31:0] mem [32];
    logic        mem_init = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  seen_wr;
    logic [13:0] seen_addr;

    tcm_mem_req_port #(
        .ID_W      (4),
        .MEM_WORDS (32),
        .RSP_DEPTH (3)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_wstrb_i  (req_wstrb_i),
        .req_id_i     (req_id_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_id_o    (resp_id_o),
        .resp_err_o   (resp_err_o),
        .ram_addr_o   (ram_addr_o),
        .ram_data_o   (ram_data_o),
        .ram_wr_o     (ram_wr_o),
        .ram_data_i   (ram_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Read-first RAM: word i starts as 0xC0DE0000 | i.
    always @(posedge clk_i) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            mem_init <= 1'b1;
        end else begin
            ram_data_i <= mem[ram_addr_o[4:0]];
            for (int b = 0; b < 4; b++) begin
                if (ram_wr_o[b]) mem[ram_addr_o[4:0]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [3:0] id);
        int n = 0;
        req_valid_i = 1'b1; req_addr_i = a; req_wdata_i = d; req_wstrb_i = s; req_id_i = id;
        #1;
        while (!req_ready_o && n < 20) begin @(negedge clk_i); #1; n++; end
        if (!req_ready_o) check("send_timeout", 64'd0, 64'd1);
        seen_wr   = ram_wr_o;
        seen_addr = ram_addr_o;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_wstrb_i = 4'h0;
        #1;
    endtask

    task automatic recv(output logic [31:0] rd, output logic [3:0] id,
                        output logic er, output int lat);
        lat = 0;
        while (!resp_valid_o && lat < 20) begin @(negedge clk_i); #1; lat++; end
        if (!resp_valid_o) check("recv_timeout", 64'd0, 64'd1);
        rd = resp_rdata_o; id = resp_id_o; er = resp_err_o;
        @(negedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [3:0]  id;
        logic        er;
        int          lat;
        int          acc;
        logic        rdy;
        logic [31:0] exp_b2b [8];
        exp_b2b = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
                    32'hDEADBEEF, 32'h1122AA44, 32'hC0DE0006, 32'hC0DE0007};

        rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        req_wstrb_i = '0; req_id_i = '0; resp_ready_i = 1'b1;

        repeat (2) @(negedge clk_i);
        #1;
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_resp_data", 64'({resp_err_o, resp_id_o, resp_rdata_o}), 64'd0);
        check("rst_ram_wr", 64'(ram_wr_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i); #1;
        check("post_rst_ready", 64'(req_ready_o), 64'd1);

        // single full-word write, then read back
        send(16'h0010, 32'hDEADBEEF, 4'hF, 4'd3);
        check("wr_strobe", 64'(seen_wr), 64'hF);
        check("wr_addr", 64'(seen_addr), 64'd4);
        recv(rd, id, er, lat);
        check("wr_latency", 64'(lat), 64'd1);
        check("wr_rsp", 64'({er, id, rd}), 64'({1'b0, 4'd3, 32'hC0DE0004}));
        send(16'h0010, 32'h0, 4'h0, 4'd4);
        check("rd_no_write", 64'(seen_wr), 64'h0);
        recv(rd, id, er, lat);
        check("rd_back", 64'({er, id, rd}), 64'({1'b0, 4'd4, 32'hDEADBEEF}));

        // byte-lane write into word 5
        send(16'h0014, 32'h11223344, 4'hF, 4'd5);
        recv(rd, id, er, lat);
        check("full_wr_rsp", 64'({er, id, rd}), 64'({1'b0, 4'd5, 32'hC0DE0005}));
        send(16'h0014, 32'h0000AA00, 4'h2, 4'd6);
        check("byte_strobe", 64'(seen_wr), 64'h2);
        recv(rd, id, er, lat);
        check("byte_wr_rsp", 64'({er, id, rd}), 64'({1'b0, 4'd6, 32'h11223344}));
        send(16'h0014, 32'h0, 4'h0, 4'd7);
        recv(rd, id, er, lat);
        check("byte_rd_back", 64'({er, id, rd}), 64'({1'b0, 4'd7, 32'h1122AA44}));

        // back-to-back reads of words 0..7
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    req_valid_i = 1'b1; req_addr_i = 16'(i * 4); req_wstrb_i = 4'h0;
                    req_id_i = 4'(i);
                    #1;
                    check("b2b_ready", 64'(req_ready_o), 64'd1);
                    @(negedge clk_i); #1;
                end
                req_valid_i = 1'b0;
            end
            begin
                int n = 0;
                #1;
                while (!resp_valid_o && n < 10) begin @(negedge clk_i); #2; n++; end
                check("b2b_first_latency", 64'(n), 64'd2);
                for (int k = 0; k < 8; k++) begin
                    check("b2b_rsp", 64'({resp_valid_o, resp_err_o, resp_id_o, resp_rdata_o}),
                          64'({1'b1, 1'b0, 4'(k), exp_b2b[k]}));
                    @(negedge clk_i); #2;
                end
                check("b2b_drained", 64'(resp_valid_o), 64'd0);
            end
        join
        @(negedge clk_i); #1;

        // back-pressure: consumer stalled, continuous request stream
        resp_ready_i = 1'b0;
        acc = 0;
        rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            req_valid_i = 1'b1; req_addr_i = 16'((8 + acc) * 4); req_id_i = 4'(8 + acc);
            req_wstrb_i = 4'h0;
            #1;
            rdy = req_ready_o;
            if (rdy) acc++;
            @(negedge clk_i); #1;
        end
        check("bp_accepts", 64'(acc), 64'd3);
        check("bp_ready_low", 64'(rdy), 64'd0);
        req_valid_i = 1'b0;
        resp_ready_i = 1'b1;
        #1;
        check("bp_head0", 64'({resp_valid_o, resp_err_o, resp_id_o, resp_rdata_o}),
              64'({1'b1, 1'b0, 4'd8, 32'hC0DE0008}));
        check("bp_ready_before_pop", 64'(req_ready_o), 64'd0);
        @(negedge clk_i); #1;
        check("bp_ready_after_pop", 64'(req_ready_o), 64'd1);
        check("bp_head1", 64'({resp_valid_o, resp_id_o, resp_rdata_o}),
              64'({1'b1, 4'd9, 32'hC0DE0009}));
        @(negedge clk_i); #1;
        check("bp_head2", 64'({resp_valid_o, resp_id_o, resp_rdata_o}),
              64'({1'b1, 4'd10, 32'hC0DE000A}));
        @(negedge clk_i); #1;
        check("bp_empty", 64'(resp_valid_o), 64'd0);

        // error requests never write and return err with zero data
        send(16'h0081, 32'hFFFFFFFF, 4'hF, 4'd11);
        check("mis_no_write", 64'(seen_wr), 64'h0);
        recv(rd, id, er, lat);
        check("mis_rsp", 64'({er, id, rd}), 64'({1'b1, 4'd11, 32'h0}));
        send(16'h0080, 32'hFFFFFFFF, 4'hF, 4'd12);
        check("oor_no_write", 64'(seen_wr), 64'h0);
        recv(rd, id, er, lat);
        check("oor_rsp", 64'({er, id, rd}), 64'({1'b1, 4'd12, 32'h0}));
        send(16'h007C, 32'h0, 4'h0, 4'd13);
        recv(rd, id, er, lat);
        check("last_word_ok", 64'({er, id, rd}), 64'({1'b0, 4'd13, 32'hC0DE001F}));
        send(16'h0000, 32'h0, 4'h0, 4'd14);
        recv(rd, id, er, lat);
        check("word0_intact", 64'({er, id, rd}), 64'({1'b0, 4'd14, 32'hC0DE0000}));

        // reset with two responses queued and one in flight
        resp_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_valid_i = 1'b1; req_addr_i = 16'((c + 1) * 4); req_id_i = 4'(c + 1);
            req_wstrb_i = 4'h0;
            @(negedge clk_i); #1;
        end
        check("pre_rst_valid", 64'(resp_valid_o), 64'd1);
        req_addr_i = 16'h0008; req_wstrb_i = 4'hF; req_wdata_i = 32'h55555555;
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 64'(resp_valid_o), 64'd0);
        check("async_rst_data", 64'({resp_err_o, resp_id_o, resp_rdata_o}), 64'd0);
        check("async_rst_ram_wr", 64'(ram_wr_o), 64'd0);
        check("async_rst_ready", 64'(req_ready_o), 64'd0);
        @(negedge clk_i); #1;
        req_valid_i = 1'b0; req_wstrb_i = 4'h0;
        rst_ni = 1'b1;
        resp_ready_i = 1'b1;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i); #1;
            if (resp_valid_o) acc++;
        end
        check("no_stale_rsp", 64'(acc), 64'd0);
        send(16'h0008, 32'h0, 4'h0, 4'd5);
        recv(rd, id, er, lat);
        check("post_rst_read", 64'({er, id, rd}), 64'({1'b0, 4'd5, 32'hC0DE0002}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
